// File: rtl/bt_redirect_ctrl.sv
// Branch-target redirect controller for the EX stage: steers the target-adder
// operand selects, captures the target and hands a redirect to IF via valid/ready.
package bt_redirect_pkg;
    typedef enum logic [0:0] {
        OP_A_REG_A  = 1'b0,
        OP_A_CURRPC = 1'b1
    } op_a_sel_e;

    typedef enum logic [1:0] {
        IMM_B_I       = 2'd0,
        IMM_B_J       = 2'd1,
        IMM_B_B       = 2'd2,
        IMM_B_INCR_PC = 2'd3
    } imm_b_sel_e;
endpackage

module bt_redirect_ctrl
    import bt_redirect_pkg::*;
#(
    parameter bit          RV32C    = 1'b1,
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ex_valid_i,
    input  logic                ex_jal_i,
    input  logic                ex_jalr_i,
    input  logic                ex_branch_i,
    input  logic                cmp_valid_i,
    input  logic                cmp_taken_i,
    input  logic [31:0]         bt_target_i,
    input  logic                kill_i,
    output op_a_sel_e           bt_a_mux_sel_o,
    output imm_b_sel_e          bt_b_mux_sel_o,
    output logic                ex_ready_o,
    output logic                redir_valid_o,
    input  logic                redir_ready_i,
    output logic [31:0]         redir_pc_o,
    output logic                flush_o,
    output logic                misalign_exc_o,
    output logic [31:0]         misalign_tval_o,
    output logic [CntWidth-1:0] taken_cnt_o
);

    typedef enum logic [1:0] {IDLE, WAIT_CMP, REDIRECT, EXC} state_e;

    state_e              state_q, state_d;
    logic [31:0]         tgt_q, tgt_d;
    op_a_sel_e           a_sel_q, a_sel_d;
    imm_b_sel_e          b_sel_q, b_sel_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    logic        is_jal, is_jalr, is_br, jalr_mask, take, misaligned;
    logic [31:0] tgt_in;

    // Class priority jal > jalr > branch.
    assign is_jal  = ex_valid_i & ex_jal_i;
    assign is_jalr = ex_valid_i & ~ex_jal_i & ex_jalr_i;
    assign is_br   = ex_valid_i & ~ex_jal_i & ~ex_jalr_i & ex_branch_i;

    assign jalr_mask  = (state_q == IDLE) && is_jalr;
    assign tgt_in     = {bt_target_i[31:1], bt_target_i[0] & ~jalr_mask};
    assign misaligned = RV32C ? tgt_in[0] : tgt_in[1];

    assign redir_pc_o  = tgt_q;
    assign taken_cnt_o = cnt_q;

    always_comb begin
        state_d         = state_q;
        tgt_d           = tgt_q;
        a_sel_d         = a_sel_q;
        b_sel_d         = b_sel_q;
        cnt_d           = cnt_q;
        take            = 1'b0;
        bt_a_mux_sel_o  = OP_A_CURRPC;
        bt_b_mux_sel_o  = IMM_B_INCR_PC;
        ex_ready_o      = 1'b0;
        redir_valid_o   = 1'b0;
        flush_o         = 1'b0;
        misalign_exc_o  = 1'b0;
        misalign_tval_o = '0;

        unique case (state_q)
            IDLE: begin
                if (is_jal) begin
                    bt_b_mux_sel_o = IMM_B_J;
                end else if (is_jalr) begin
                    bt_a_mux_sel_o = OP_A_REG_A;
                    bt_b_mux_sel_o = IMM_B_I;
                end else if (is_br) begin
                    bt_b_mux_sel_o = IMM_B_B;
                end

                if (is_jal || is_jalr || (is_br && cmp_valid_i && cmp_taken_i)) begin
                    take = 1'b1;
                end else if (is_br && !cmp_valid_i) begin
                    state_d = WAIT_CMP;
                    a_sel_d = bt_a_mux_sel_o;
                    b_sel_d = bt_b_mux_sel_o;
                end else begin
                    ex_ready_o = ex_valid_i;
                end
            end
            WAIT_CMP: begin
                bt_a_mux_sel_o = a_sel_q;
                bt_b_mux_sel_o = b_sel_q;
                if (cmp_valid_i) begin
                    if (cmp_taken_i) begin
                        take = 1'b1;
                    end else begin
                        ex_ready_o = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            REDIRECT: begin
                bt_a_mux_sel_o = a_sel_q;
                bt_b_mux_sel_o = b_sel_q;
                redir_valid_o  = 1'b1;
                if (redir_ready_i) begin
                    flush_o    = 1'b1;
                    ex_ready_o = 1'b1;
                    state_d    = IDLE;
                    if (cnt_q != {CntWidth{1'b1}}) cnt_d = cnt_q + 1'b1;
                end
            end
            EXC: begin
                misalign_exc_o  = 1'b1;
                misalign_tval_o = tgt_q;
                ex_ready_o      = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            tgt_d   = tgt_in;
            a_sel_d = bt_a_mux_sel_o;
            b_sel_d = bt_b_mux_sel_o;
            state_d = misaligned ? EXC : REDIRECT;
        end

        // Kill and reset abort whatever is in flight; kill beats a same-cycle handshake.
        if (kill_i || rst_i) begin
            ex_ready_o     = 1'b0;
            redir_valid_o  = 1'b0;
            flush_o        = 1'b0;
            misalign_exc_o = 1'b0;
            state_d        = IDLE;
            tgt_d          = tgt_q;
            a_sel_d        = a_sel_q;
            b_sel_d        = b_sel_q;
            cnt_d          = cnt_q;
        end

        if (rst_i) begin
            bt_a_mux_sel_o  = OP_A_CURRPC;
            bt_b_mux_sel_o  = IMM_B_INCR_PC;
            misalign_tval_o = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            a_sel_q <= OP_A_CURRPC;
            b_sel_q <= IMM_B_INCR_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            a_sel_q <= a_sel_d;
            b_sel_q <= b_sel_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bt_redirect_ctrl.sv
// Bench for bt_redirect_ctrl: cycle-by-cycle vector table on the default build,
// redirect scoreboard, and hand sequences on an RV32C=0 / CntWidth=2 build.
module tb_bt_redirect_ctrl;
    import bt_redirect_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        ex_valid_i = 1'b0, ex_jal_i = 1'b0, ex_jalr_i = 1'b0, ex_branch_i = 1'b0;
    logic        cmp_valid_i = 1'b0, cmp_taken_i = 1'b0, kill_i = 1'b0, redir_ready_i = 1'b0;
    logic [31:0] bt_target_i = '0;

    op_a_sel_e   a_sel, a_sel2;
    imm_b_sel_e  b_sel, b_sel2;
    logic        ex_ready, rv, flush, exc, ex_ready2, rv2, flush2, exc2;
    logic [31:0] pc, tval, pc2, tval2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    always #5 clk = ~clk;

    bt_redirect_ctrl u_dut (
        .clk_i(clk), .rst_i(rst_i), .ex_valid_i(ex_valid_i), .ex_jal_i(ex_jal_i),
        .ex_jalr_i(ex_jalr_i), .ex_branch_i(ex_branch_i), .cmp_valid_i(cmp_valid_i),
        .cmp_taken_i(cmp_taken_i), .bt_target_i(bt_target_i), .kill_i(kill_i),
        .bt_a_mux_sel_o(a_sel), .bt_b_mux_sel_o(b_sel), .ex_ready_o(ex_ready),
        .redir_valid_o(rv), .redir_ready_i(redir_ready_i), .redir_pc_o(pc),
        .flush_o(flush), .misalign_exc_o(exc), .misalign_tval_o(tval), .taken_cnt_o(cnt)
    );

    bt_redirect_ctrl #(.RV32C(1'b0), .CntWidth(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst_i), .ex_valid_i(ex_valid_i), .ex_jal_i(ex_jal_i),
        .ex_jalr_i(ex_jalr_i), .ex_branch_i(ex_branch_i), .cmp_valid_i(cmp_valid_i),
        .cmp_taken_i(cmp_taken_i), .bt_target_i(bt_target_i), .kill_i(kill_i),
        .bt_a_mux_sel_o(a_sel2), .bt_b_mux_sel_o(b_sel2), .ex_ready_o(ex_ready2),
        .redir_valid_o(rv2), .redir_ready_i(redir_ready_i), .redir_pc_o(pc2),
        .flush_o(flush2), .misalign_exc_o(exc2), .misalign_tval_o(tval2), .taken_cnt_o(cnt2)
    );

    typedef struct {
        int          rst, ev, jal, jalr, br, cv, ct, kill, rdy;
        logic [31:0] tgt;
        int          push;
        logic [31:0] ppc;
        int          a, b, er, rv, fl, exc;
        logic [31:0] pc, tval;
        int          cnt;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_q[$];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got 0x%08h want 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic set_in(input int ev, input int jal, input int jalr, input int br,
                          input logic [31:0] tgt, input int rdy);
        @(posedge clk); #1;
        rst_i = 1'b0; kill_i = 1'b0; cmp_valid_i = 1'b0; cmp_taken_i = 1'b0;
        ex_valid_i = 1'(ev); ex_jal_i = 1'(jal); ex_jalr_i = 1'(jalr); ex_branch_i = 1'(br);
        bt_target_i = tgt; redir_ready_i = 1'(rdy);
        #4;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_i = 1'b1; ex_valid_i = 1'b0; ex_jal_i = 1'b0; ex_jalr_i = 1'b0; ex_branch_i = 1'b0;
        cmp_valid_i = 1'b0; cmp_taken_i = 1'b0; kill_i = 1'b0; redir_ready_i = 1'b0;
        #4;
    endtask

    initial begin
        // rst ev jal jalr br cv ct kill rdy  tgt  push ppc  a b er rv fl exc  pc tval cnt
        vecs.push_back(vec_t'{1,1,1,0,0,0,0,0,1, 32'h140, 0,32'h0, 1,3,0,0,0,0, 32'h0,32'h0,0});
        vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0, 32'h0,   0,32'h0, 1,3,0,0,0,0, 32'h0,32'h0,0});
        vecs.push_back(vec_t'{0,1,0,0,0,0,0,0,0, 32'h0,   0,32'h0, 1,3,1,0,0,0, 32'h0,32'h0,0});
        vecs.push_back(vec_t'{0,1,1,0,0,0,0,0,1, 32'h140, 1,32'h140, 1,1,0,0,0,0, 32'h0,32'h0,0});
        vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,1, 32'hdead,0,32'h0, 1,1,1,1,1,0, 32'h140,32'h0,0});
        vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0, 32'h0,   0,32'h0, 1,3,0,0,0,0, 32'h140,32'h0,1});
        vecs.push_back(vec_t'{0,1,0,1,0,0,0,0,0, 32'h2001,1,32'h2000, 0,0,0,0,0,0, 32'h140,32'h0,1});
        for (int k = 0; k < 3; k++)
            vecs.push_back(vec_t'{0,1,0,1,0,0,0,0,0, 32'h2001,0,32'h0, 0,0,0,1,0,0, 32'h2000,32'h0,1});
        vecs.push_back(vec_t'{0,1,0,1,0,0,0,0,1, 32'h2001,0,32'h0, 0,0,1,1,1,0, 32'h2000,32'h0,1});
        vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0, 32'h0,   0,32'h0, 1,3,0,0,0,0, 32'h2000,32'h0,2});
        vecs.push_back(vec_t'{0,1,0,0,1,0,0,0,0, 32'h80,  0,32'h0, 1,2,0,0,0,0, 32'h2000,32'h0,2});
        vecs.push_back(vec_t'{0,1,0,0,1,0,0,0,0, 32'h80,  0,32'h0, 1,2,0,0,0,0, 32'h2000,32'h0,2});
        vecs.push_back(vec_t'{0,1,0,0,1,1,1,0,0, 32'h80,  1,32'h80, 1,2,0,0,0,0, 32'h2000,32'h0,2});
        vecs.push_back(vec_t'{0,1,0,0,1,0,0,0,1, 32'h80,  0,32'h0, 1,2,1,1,1,0, 32'h80,32'h0,2});
        vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0, 32'h0,   0,32'h0, 1,3,0,0,0,0, 32'h80,32'h0,3});
        // not-taken repeat with late compare
        vecs.push_back(vec_t'{0,1,0,0,1,0,0,0,0, 32'h80,  0,32'h0, 1,2,0,0,0,0, 32'h80,32'h0,3});
        vecs.push_back(vec_t'{0,1,0,0,1,0,0,0,0, 32'h80,  0,32'h0, 1,2,0,0,0,0, 32'h80,32'h0,3});
        vecs.push_back(vec_t'{0,1,0,0,1,1,0,0,0, 32'h80,  0,32'h0, 1,2,1,0,0,0, 32'h80,32'h0,3});
        vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0, 32'h0,   0,32'h0, 1,3,0,0,0,0, 32'h80,32'h0,3});
        // same-cycle not-taken, then same-cycle taken killed during the handshake
        vecs.push_back(vec_t'{0,1,0,0,1,1,0,0,0, 32'h80,  0,32'h0, 1,2,1,0,0,0, 32'h80,32'h0,3});
        vecs.push_back(vec_t'{0,1,0,0,1,1,1,0,0, 32'h300, 0,32'h0, 1,2,0,0,0,0, 32'h80,32'h0,3});
        vecs.push_back(vec_t'{0,1,0,0,1,0,0,1,1, 32'h300, 0,32'h0, 1,2,0,0,0,0, 32'h300,32'h0,3});
        vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0, 32'h0,   0,32'h0, 1,3,0,0,0,0, 32'h300,32'h0,3});
        // all classes set: jal wins, so the odd target is not masked and traps
        vecs.push_back(vec_t'{0,1,1,1,1,0,0,0,0, 32'h445, 0,32'h0, 1,1,0,0,0,0, 32'h300,32'h0,3});
        vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0, 32'h0,   0,32'h0, 1,3,1,0,0,1, 32'h445,32'h445,3});
        vecs.push_back(vec_t'{0,1,0,1,1,0,0,0,1, 32'h601, 1,32'h600, 0,0,0,0,0,0, 32'h445,32'h0,3});
        vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,1, 32'h0,   0,32'h0, 0,0,1,1,1,0, 32'h600,32'h0,3});
        vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0, 32'h0,   0,32'h0, 1,3,0,0,0,0, 32'h600,32'h0,4});
        // reset while waiting for the compare
        vecs.push_back(vec_t'{0,1,0,0,1,0,0,0,0, 32'h80,  0,32'h0, 1,2,0,0,0,0, 32'h600,32'h0,4});
        vecs.push_back(vec_t'{1,1,0,0,1,0,0,0,1, 32'h80,  0,32'h0, 1,3,0,0,0,0, 32'h600,32'h0,4});
        vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0, 32'h0,   0,32'h0, 1,3,0,0,0,0, 32'h0,32'h0,0});

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            rst_i = 1'(vecs[i].rst); ex_valid_i = 1'(vecs[i].ev); ex_jal_i = 1'(vecs[i].jal);
            ex_jalr_i = 1'(vecs[i].jalr); ex_branch_i = 1'(vecs[i].br);
            cmp_valid_i = 1'(vecs[i].cv); cmp_taken_i = 1'(vecs[i].ct);
            kill_i = 1'(vecs[i].kill); redir_ready_i = 1'(vecs[i].rdy); bt_target_i = vecs[i].tgt;
            if (vecs[i].push != 0) sb_q.push_back(vecs[i].ppc);
            #4;
            chk("a_sel", i, 32'(a_sel), 32'(vecs[i].a));
            chk("b_sel", i, 32'(b_sel), 32'(vecs[i].b));
            chk("ex_ready", i, 32'(ex_ready), 32'(vecs[i].er));
            chk("redir_valid", i, 32'(rv), 32'(vecs[i].rv));
            chk("flush", i, 32'(flush), 32'(vecs[i].fl));
            chk("misalign_exc", i, 32'(exc), 32'(vecs[i].exc));
            chk("redir_pc", i, pc, vecs[i].pc);
            chk("tval", i, tval, vecs[i].tval);
            chk("taken_cnt", i, 32'(cnt), 32'(vecs[i].cnt));
            if (rv && redir_ready_i && !kill_i) begin
                if (sb_q.size() == 0) chk("sb_unexpected", i, pc, 32'hffff_ffff);
                else chk("sb_pc", i, pc, sb_q.pop_front());
            end
        end
        chk("sb_empty", 0, 32'(sb_q.size()), 32'h0);

        // RV32C=0: jal to 0x102 traps; the compressed build redirects instead
        do_reset();
        set_in(1, 1, 0, 0, 32'h102, 1);
        chk("d2_exc_c0", 0, 32'(exc2), 32'h0);
        chk("d2_ready_c0", 0, 32'(ex_ready2), 32'h0);
        set_in(0, 0, 0, 0, 32'h0, 1);
        chk("d2_exc_c1", 1, 32'(exc2), 32'h1);
        chk("d2_tval_c1", 1, tval2, 32'h102);
        chk("d2_rv_c1", 1, 32'(rv2), 32'h0);
        chk("d2_flush_c1", 1, 32'(flush2), 32'h0);
        chk("d2_ready_c1", 1, 32'(ex_ready2), 32'h1);
        chk("d1_rv_c1", 1, 32'(rv), 32'h1);
        chk("d1_pc_c1", 1, pc, 32'h102);
        set_in(0, 0, 0, 0, 32'h0, 0);
        chk("d2_exc_c2", 2, 32'(exc2), 32'h0);
        chk("d2_cnt_c2", 2, 32'(cnt2), 32'h0);
        chk("d1_cnt_c2", 2, 32'(cnt), 32'h1);

        // 2-bit counter saturates at 3 across five redirects
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            set_in(1, 1, 0, 0, 32'h200 + 32'(k * 4), 1);
            set_in(0, 0, 0, 0, 32'h0, 1);
            chk("d2_rv_sat", k, 32'(rv2), 32'h1);
            chk("d2_pc_sat", k, pc2, 32'h200 + 32'(k * 4));
            set_in(0, 0, 0, 0, 32'h0, 0);
            chk("d2_cnt_sat", k, 32'(cnt2), 32'((k < 3) ? k : 3));
            chk("d1_cnt_sat", k, 32'(cnt), 32'(k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
